inst_loader: RTL

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader_if.sv | 30 +++
 rtl/inst_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/inst_loader_if.sv
// Handshake bundle between the debug-UART byte stream and the instruction-memory write port.
// The loader core connects through the slave modport; the stream source connects through the master modport.
interface inst_loader_if #(
    parameter int MEM_SIZE      = 8,
    parameter int DIR_ADDR_SIZE = 8
);
    logic                     i_start;
    logic [MEM_SIZE-1:0]      i_rx_data;
    logic                     i_rx_valid;
    logic                     o_mem_enable;
    logic                     o_mem_write_enable;
    logic [DIR_ADDR_SIZE-1:0] o_mem_write_addr;
    logic [MEM_SIZE-1:0]      o_mem_write_data;
    logic                     o_busy;
    logic                     o_done;
    logic                     o_error;
    logic [DIR_ADDR_SIZE-1:0] o_word_count;

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_mem_enable, o_mem_write_enable, o_mem_write_addr, o_mem_write_data,
        input  o_busy, o_done, o_error, o_word_count
    );

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_mem_enable, o_mem_write_enable, o_mem_write_addr, o_mem_write_data,
        output o_busy, o_done, o_error, o_word_count
    );
endinterface

// File: rtl/inst_loader.sv
// Loads a program byte-by-byte from the debug UART into instruction memory, assembling
// big-endian 32-bit words and stopping on the halt word or when memory is full.
module inst_loader #(
    parameter int          MEM_SIZE      = 8,
    parameter int          DIR_ADDR_SIZE = 8,
    parameter int          ENTRIES_SIZE  = 256,
    parameter logic [31:0] HALT_WORD     = 32'hFFFFFFFF
) (
    input  logic         i_clock,
    input  logic         i_reset,
    inst_loader_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    localparam logic [DIR_ADDR_SIZE-1:0] LAST_ADDR = DIR_ADDR_SIZE'(ENTRIES_SIZE - 1);

    state_e                   state_q, state_d;
    logic [DIR_ADDR_SIZE-1:0] ptr_q, ptr_d;
    logic [1:0]               byte_cnt_q, byte_cnt_d;
    logic [23:0]              word_q, word_d;
    logic [DIR_ADDR_SIZE-1:0] word_count_q, word_count_d;
    logic                     wr_en_q, wr_en_d;
    logic [DIR_ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [MEM_SIZE-1:0]      wr_data_q, wr_data_d;
    logic                     mem_en_q, mem_en_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;

    logic [7:0]               byte_s;
    logic [31:0]              word_s;
    logic                     word_last_s;
    logic                     halt_s;

    // Only the first three bytes of a word are stored; the fourth arrives live.
    assign byte_s      = 8'(bus.i_rx_data);
    assign word_s      = {word_q, byte_s};
    assign word_last_s = (byte_cnt_q == 2'd3);
    assign halt_s      = word_last_s && (word_s == HALT_WORD);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        word_count_d = word_count_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (bus.i_start) begin
                    state_d      = ST_LOAD;
                    ptr_d        = {DIR_ADDR_SIZE{1'b0}};
                    byte_cnt_d   = 2'd0;
                    word_d       = 24'd0;
                    word_count_d = {DIR_ADDR_SIZE{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (bus.i_rx_valid) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = ptr_q;
                    wr_data_d  = bus.i_rx_data;
                    word_d     = word_s[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (word_last_s) begin
                        word_count_d = word_count_q + {{(DIR_ADDR_SIZE-1){1'b0}}, 1'b1};
                    end else begin
                        word_count_d = word_count_q;
                    end
                    // Halt on the final word wins over the memory-full error.
                    if (halt_s) begin
                        state_d = ST_DONE;
                    end else if (ptr_q == LAST_ADDR) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                    // The pointer parks on the last address instead of wrapping.
                    if (ptr_q != LAST_ADDR) begin
                        ptr_d = ptr_q + {{(DIR_ADDR_SIZE-1){1'b0}}, 1'b1};
                    end else begin
                        ptr_d = ptr_q;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_en_d = (state_d == ST_LOAD) || wr_en_d;
        busy_d   = (state_d == ST_LOAD);
        done_d   = (state_d == ST_DONE);
        error_d  = (state_d == ST_ERROR);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= {DIR_ADDR_SIZE{1'b0}};
            byte_cnt_q   <= 2'd0;
            word_q       <= 24'd0;
            word_count_q <= {DIR_ADDR_SIZE{1'b0}};
            wr_en_q      <= 1'b0;
            wr_addr_q    <= {DIR_ADDR_SIZE{1'b0}};
            wr_data_q    <= {MEM_SIZE{1'b0}};
            mem_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            word_count_q <= word_count_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            mem_en_q     <= mem_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.o_mem_enable       = mem_en_q;
    assign bus.o_mem_write_enable = wr_en_q;
    assign bus.o_mem_write_addr   = wr_addr_q;
    assign bus.o_mem_write_data   = wr_data_q;
    assign bus.o_busy             = busy_q;
    assign bus.o_done             = done_q;
    assign bus.o_error            = error_q;
    assign bus.o_word_count       = word_count_q;

endmodule
